// File: rtl/rotate_left_seq.sv
// Iterative left rotator / logical left shifter driven by a start/done handshake.
// Define ROTL_DOUBLE_STEP_EN to advance two bit positions per RUN cycle when count allows.
module rotate_left_seq #(
   parameter int OPERAND_WIDTH = 16,
   parameter int SHAMT_WIDTH   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [OPERAND_WIDTH-1:0] In,
   input  logic [SHAMT_WIDTH-1:0]   ShAmt,
   input  logic                     Mode,
   output logic                     ready,
   output logic                     busy,
   output logic                     done,
   output logic [OPERAND_WIDTH-1:0] result
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                   state_q;
   logic [OPERAND_WIDTH-1:0] wrk_q;
   logic [SHAMT_WIDTH-1:0]   cnt_q;
   logic                     mode_q;
   logic                     ready_q;
   logic                     busy_q;
   logic                     done_q;
   logic [OPERAND_WIDTH-1:0] result_q;

   logic [OPERAND_WIDTH-1:0] wrk_d;
   logic [SHAMT_WIDTH-1:0]   cnt_d;
   logic                     step2;

   // One position left; Mode 0 wraps the MSB into the LSB, Mode 1 fills with zero.
   function automatic logic [OPERAND_WIDTH-1:0] rotl1(
      input logic [OPERAND_WIDTH-1:0] x,
      input logic                     zero_fill
   );
      return {x[OPERAND_WIDTH-2:0], (zero_fill ? 1'b0 : x[OPERAND_WIDTH-1])};
   endfunction

   always_comb begin
      step2 = 1'b0;
`ifdef ROTL_DOUBLE_STEP_EN
      step2 = (cnt_q >= SHAMT_WIDTH'(2));
`else
      step2 = 1'b0;
`endif
      wrk_d = rotl1(wrk_q, mode_q);
      cnt_d = cnt_q - SHAMT_WIDTH'(1);
      if (step2) begin
         wrk_d = rotl1(wrk_d, mode_q);
         cnt_d = cnt_q - SHAMT_WIDTH'(2);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         wrk_q    <= '0;
         cnt_q    <= '0;
         mode_q   <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  wrk_q  <= In;
                  cnt_q  <= ShAmt;
                  mode_q <= Mode;
                  // A zero amount skips RUN entirely and returns the operand unchanged.
                  if (ShAmt == '0) begin
                     state_q  <= S_DONE;
                     done_q   <= 1'b1;
                     result_q <= In;
                     ready_q  <= 1'b1;
                     busy_q   <= 1'b0;
                  end else begin
                     state_q <= S_RUN;
                     ready_q <= 1'b0;
                     busy_q  <= 1'b1;
                  end
               end else begin
                  state_q <= S_IDLE;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            S_RUN: begin
               wrk_q <= wrk_d;
               cnt_q <= cnt_d;
               if (cnt_d == '0) begin
                  state_q  <= S_DONE;
                  done_q   <= 1'b1;
                  result_q <= wrk_d;
                  ready_q  <= 1'b1;
                  busy_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ready  = ready_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_rotate_left_seq.sv
// Bench for rotate_left_seq: directed ops from the block's test plan plus random ops
// against an arithmetic rotate/shift model.
module tb_rotate_left_seq;

   localparam int W  = 16;
   localparam int SW = 4;

   logic          clk;
   logic          rst;
   logic          start;
   logic [W-1:0]  In;
   logic [SW-1:0] ShAmt;
   logic          Mode;
   logic          ready;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;

   int n_cmp = 0;
   int n_err = 0;

   rotate_left_seq #(.OPERAND_WIDTH(W), .SHAMT_WIDTH(SW)) dut (
      .clk(clk), .rst(rst), .start(start), .In(In), .ShAmt(ShAmt), .Mode(Mode),
      .ready(ready), .busy(busy), .done(done), .result(result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] ref_op(input logic [W-1:0] x, input int sh, input logic m);
      int n;
      if (m) return (sh >= W) ? '0 : W'(x << sh);
      n = sh % W;
      if (n == 0) return x;
      return W'((x << n) | (x >> (W - n)));
   endfunction

   function automatic int ref_lat(input int sh);
`ifdef ROTL_DOUBLE_STEP_EN
      return (sh + 1) / 2;
`else
      return sh;
`endif
   endfunction

   // Issue one op and report result, edges from accept to done, and busy cycles seen.
   task automatic do_op(input logic [W-1:0] x, input int sh, input logic m,
                        output logic [W-1:0] res, output int lat, output int bc);
      @(negedge clk);
      In = x; ShAmt = SW'(sh); Mode = m; start = 1'b1;
      @(posedge clk);
      lat = -1; bc = 0; res = 'x;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (n == 0) begin
            start = 1'b0; In = $urandom; ShAmt = $urandom; Mode = $urandom;
         end
         if (busy) bc++;
         if (done) begin
            lat = n; res = result;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; In = '0; ShAmt = '0; Mode = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", ready); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
      n_cmp++; if (result !== 16'h0000) begin n_err++; $display("FAIL reset_result got %h want 0000", result); end
   endtask

   task automatic test_rotate;
      logic [W-1:0] r; int lat, bc;
      do_op(16'h8001, 1, 1'b0, r, lat, bc);
      n_cmp++; if (r !== 16'h0003) begin n_err++; $display("FAIL rot1_result got %h want 0003", r); end
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL rot1_latency got %0d want 1", lat); end
      n_cmp++; if (bc !== 1) begin n_err++; $display("FAIL rot1_busy got %0d want 1", bc); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse got %b want 0", done); end
      do_op(16'h1234, 4, 1'b0, r, lat, bc);
      n_cmp++; if (r !== 16'h2341) begin n_err++; $display("FAIL rot4_result got %h want 2341", r); end
      n_cmp++; if (lat !== ref_lat(4)) begin n_err++; $display("FAIL rot4_latency got %0d want %0d", lat, ref_lat(4)); end
      do_op(16'h0001, 15, 1'b0, r, lat, bc);
      n_cmp++; if (r !== 16'h8000) begin n_err++; $display("FAIL rot15_result got %h want 8000", r); end
      n_cmp++; if (lat !== ref_lat(15)) begin n_err++; $display("FAIL rot15_latency got %0d want %0d", lat, ref_lat(15)); end
   endtask

   task automatic test_shift_and_zero;
      logic [W-1:0] r; int lat, bc;
      do_op(16'hF00F, 4, 1'b1, r, lat, bc);
      n_cmp++; if (r !== 16'h00F0) begin n_err++; $display("FAIL shl4_result got %h want 00f0", r); end
      do_op(16'hABCD, 0, 1'b0, r, lat, bc);
      n_cmp++; if (r !== 16'hABCD) begin n_err++; $display("FAIL zero_result got %h want abcd", r); end
      n_cmp++; if (lat !== 0) begin n_err++; $display("FAIL zero_latency got %0d want 0", lat); end
      n_cmp++; if (bc !== 0) begin n_err++; $display("FAIL zero_busy got %0d want 0", bc); end
   endtask

   task automatic test_back_to_back;
      int lat;
      @(negedge clk);
      In = 16'h00FF; ShAmt = 4'd8; Mode = 1'b0; start = 1'b1;
      @(posedge clk);
      lat = -1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (n == 0) begin
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy got %b want 1", busy); end
            n_cmp++; if (result !== 16'hABCD) begin n_err++; $display("FAIL b2b_hold got %h want abcd", result); end
            start = 1'b1; In = 16'h1111; ShAmt = 4'd1;
         end else if (n == 1) begin
            start = 1'b0;
         end
         if (done) begin lat = n; break; end
      end
      n_cmp++; if (lat !== ref_lat(8)) begin n_err++; $display("FAIL b2b_first_latency got %0d want %0d", lat, ref_lat(8)); end
      n_cmp++; if (result !== 16'hFF00) begin n_err++; $display("FAIL b2b_first_result got %h want ff00", result); end
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got %b want 1", ready); end
      start = 1'b1; In = 16'h0F00; ShAmt = 4'd4; Mode = 1'b0;
      @(posedge clk);
      lat = -1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (n == 0) start = 1'b0;
         if (done) begin lat = n; break; end
      end
      n_cmp++; if (lat !== ref_lat(4)) begin n_err++; $display("FAIL b2b_second_latency got %0d want %0d", lat, ref_lat(4)); end
      n_cmp++; if (result !== 16'hF000) begin n_err++; $display("FAIL b2b_second_result got %h want f000", result); end
   endtask

   task automatic test_reset_abort;
      logic [W-1:0] r; int lat, bc, seen;
      @(negedge clk);
      In = 16'h1357; ShAmt = 4'd10; Mode = 1'b0; start = 1'b1;
      @(posedge clk);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      n_cmp++; if (ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL abort_state got ready=%b busy=%b want 1 0", ready, busy); end
      n_cmp++; if (result !== 16'h0000) begin n_err++; $display("FAIL abort_result got %h want 0000", result); end
      seen = 0;
      for (int n = 0; n < 16; n++) begin
         if (done) seen++;
         @(negedge clk);
      end
      n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL abort_done_pulses got %0d want 0", seen); end
      do_op(16'h0002, 1, 1'b0, r, lat, bc);
      n_cmp++; if (r !== 16'h0004) begin n_err++; $display("FAIL after_abort_result got %h want 0004", r); end
   endtask

   task automatic test_random;
      logic [W-1:0] x, r, e; int sh, lat, bc; logic m;
      for (int i = 0; i < 40; i++) begin
         x = $urandom; sh = $urandom_range(0, 15); m = $urandom_range(0, 1);
         e = ref_op(x, sh, m);
         do_op(x, sh, m, r, lat, bc);
         n_cmp++; if (r !== e) begin n_err++; $display("FAIL rand_result in=%h sh=%0d m=%b got %h want %h", x, sh, m, r, e); end
         n_cmp++; if (lat !== ref_lat(sh)) begin n_err++; $display("FAIL rand_latency sh=%0d got %0d want %0d", sh, lat, ref_lat(sh)); end
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
   endtask

   initial begin
      test_reset;
      test_rotate;
      test_shift_and_zero;
      test_back_to_back;
      test_reset_abort;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rotate_left_seq.md
Name: rotate_left_seq

Overview:
- Iterative multi-cycle left rotator/shifter for the 16-bit datapath. It is the left-direction counterpart of the combinational right rotator.
- Rotates (or logically shifts) an operand left by 1 bit per cycle under a start/done handshake.
- Used by the execute-stage sequencer for left-rotate and left-shift ops where a full combinational barrel is not wanted.

Parameters:
- OPERAND_WIDTH, 16, operand/result width in bits.
- SHAMT_WIDTH, 4, shift-amount width; max amount 2^SHAMT_WIDTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- In  input  OPERAND_WIDTH  operand, sampled at accept edge.
- ShAmt  input  SHAMT_WIDTH  amount, sampled at accept edge.
- Mode  input  1  0=rotate left (MSB wraps to LSB); 1=logical shift left (zero fill). Sampled at accept edge.
- ready  output  1  high when a start will be accepted (state IDLE or DONE).
- busy  output  1  high in state RUN.
- done  output  1  single-cycle pulse: result valid.
- result  output  OPERAND_WIDTH  operation result; held until the next accept.

Behaviour:
- One clock; reset is synchronous and active-high. It is sampled only at the clk rising edge.
- Reset values: state=IDLE, ready=1, busy=0, done=0, result=0, internal count=0.
- States are IDLE, RUN and DONE.
- IDLE, start=1: latch In into the working reg, ShAmt into count, and Mode.
  - count==0 -> DONE.
  - Otherwise -> RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each edge:
  - Mode 0: reg <= {reg[W-2:0], reg[W-1]}.
  - Mode 1: reg <= {reg[W-2:0], 1'b0}.
  - count <= count-1.
  - If count==1 before the edge -> DONE. Otherwise stay in RUN.
- RUN ignores start; the request is dropped, not queued.
- DONE: done=1 for exactly this cycle, and result equals the final reg value.
  - start=1 in DONE is accepted with the same rules as IDLE (back-to-back ops).
  - Otherwise -> IDLE.
- Latency: with accept at edge E0, done is high in the cycle after edge E0+ShAmt.
  - ShAmt=0 gives done after E0, with result=In.
  - ShAmt=15 gives done after E0+15.
- result updates only on the edge entering DONE. It is stable in IDLE and RUN, and holds the previous op's value during RUN.
- Width rule: shift is modulo OPERAND_WIDTH for rotate. Mode 1 with ShAmt >= OPERAND_WIDTH is unreachable at default widths. If parameters allow it, the result is 0.
- In/ShAmt/Mode changes after the accept edge have no effect on the op in progress.
- rst during RUN or DONE: next state IDLE, done=0, result=0, and the op is aborted with no done pulse.
- rst and start in the same cycle: rst wins and start is ignored.

Optional Feature:
- Macro ROTL_DOUBLE_STEP_EN.
- Defined: in RUN, if count>=2, the reg moves 2 positions and count decrements by 2. Otherwise it moves 1 position and count decrements by 1. The transition to DONE occurs when count after the step is 0.
  - Latency becomes ceil(ShAmt/2) edges after E0; ShAmt=0 still gives done after E0.
- Undefined: 1 position per cycle exactly as described above.
- Final result values are identical in both builds.

Test Plan:
- Reset, then idle 3 cycles -> ready=1, busy=0, done=0, result=16'h0000.
- In=16'h8001, ShAmt=1, Mode=0, start for 1 cycle:
  - done after E0+1 (after E0+1 also with ROTL_DOUBLE_STEP_EN), result=16'h0003.
  - busy=1 for 1 cycle.
- In=16'h1234, ShAmt=4, Mode=0 -> result=16'h2341, done after E0+4 (E0+2 with ROTL_DOUBLE_STEP_EN). Then In=16'h0001, ShAmt=15 -> result=16'h8000, done after E0+15 (E0+8 with ROTL_DOUBLE_STEP_EN).
- In=16'hF00F, ShAmt=4, Mode=1 -> result=16'h00F0. Then ShAmt=0, In=16'hABCD -> result=16'hABCD with done after E0 and busy never high.
- Start In=16'h00FF, ShAmt=8. During RUN, pulse start with In=16'h1111 -> ignored, result=16'hFF00. On the DONE cycle, assert start with In=16'h0F00, ShAmt=4 -> accepted back-to-back, result=16'hF000.
- Start ShAmt=10, assert rst after 3 RUN cycles -> next cycle IDLE, result=0, no done pulse. A subsequent op with In=16'h0002, ShAmt=1 -> result=16'h0004.
